// File: rtl/riscv_du_rf_access.sv
// Debug-unit bridge from a debugger register request to the core register-file debug port.
// Optional macro RV_DU_RF_ADDR_CHECK_EN rejects addresses with bits [11:5] set via an error ack.
module riscv_du_rf_access #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            dbg_req_i,
    input  logic            dbg_we_i,
    input  logic [11:0]     dbg_addr_i,
    input  logic [XLEN-1:0] dbg_wdata_i,
    output logic            dbg_ack_o,
    output logic [XLEN-1:0] dbg_rdata_o,
    output logic            dbg_err_o,
    input  logic            du_stall_i,
    output logic            du_re_rf_o,
    output logic            du_we_rf_o,
    output logic [11:0]     du_addr_o,
    output logic [XLEN-1:0] du_d_o,
    input  logic [XLEN-1:0] du_rf_q_i
);

    typedef enum logic [2:0] {StIdle, StRd, StRdW, StRdCap, StWr, StAck} state_e;

    state_e            state_q;
    logic              ack_q;
    logic              err_q;
    logic              re_q;
    logic              we_q;
    logic [11:0]       addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              addr_err;

`ifdef RV_DU_RF_ADDR_CHECK_EN
    assign addr_err = |dbg_addr_i[11:5];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^dbg_addr_i[11:5];
    assign addr_err       = 1'b0;
`endif

    // Strobes are registered on the edge that enters RD/WR, so they line up with that state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            re_q  <= 1'b0;
            we_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (dbg_req_i && du_stall_i) begin
                        if (addr_err) begin
                            state_q <= StAck;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            addr_q <= {7'b0, dbg_addr_i[4:0]};
                            if (dbg_we_i) begin
                                state_q <= StWr;
                                wdata_q <= dbg_wdata_i;
                                // x0 is hardwired; the write still completes without a strobe.
                                we_q    <= |dbg_addr_i[4:0];
                            end else begin
                                state_q <= StRd;
                                re_q    <= 1'b1;
                            end
                        end
                    end
                end
                StRd:    state_q <= StRdW;
                StRdW:   state_q <= StRdCap;
                StRdCap: begin
                    rdata_q <= du_rf_q_i;
                    state_q <= StAck;
                    ack_q   <= 1'b1;
                end
                StWr: begin
                    state_q <= StAck;
                    ack_q   <= 1'b1;
                end
                StAck:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dbg_ack_o   = ack_q;
    assign dbg_err_o   = err_q;
    assign dbg_rdata_o = rdata_q;
    assign du_re_rf_o  = re_q;
    assign du_we_rf_o  = we_q;
    assign du_addr_o   = addr_q;
    assign du_d_o      = wdata_q;

endmodule

// File: tb/tb_riscv_du_rf_access.sv
// Scoreboard bench for riscv_du_rf_access: stimulus pushes expected transactions,
// a negedge monitor checks strobes and acks against them.
module tb_riscv_du_rf_access;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        dbg_req_i = 1'b0;
    logic        dbg_we_i = 1'b0;
    logic [11:0] dbg_addr_i = '0;
    logic [31:0] dbg_wdata_i = '0;
    logic        dbg_ack_o;
    logic [31:0] dbg_rdata_o;
    logic        dbg_err_o;
    logic        du_stall_i = 1'b0;
    logic        du_re_rf_o;
    logic        du_we_rf_o;
    logic [11:0] du_addr_o;
    logic [31:0] du_d_o;
    logic [31:0] du_rf_q_i;

    riscv_du_rf_access #(.XLEN(32)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .dbg_req_i   (dbg_req_i),
        .dbg_we_i    (dbg_we_i),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_wdata_i (dbg_wdata_i),
        .dbg_ack_o   (dbg_ack_o),
        .dbg_rdata_o (dbg_rdata_o),
        .dbg_err_o   (dbg_err_o),
        .du_stall_i  (du_stall_i),
        .du_re_rf_o  (du_re_rf_o),
        .du_we_rf_o  (du_we_rf_o),
        .du_addr_o   (du_addr_o),
        .du_d_o      (du_d_o),
        .du_rf_q_i   (du_rf_q_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Register file model: data appears two cycles after the read-strobe cycle, garbage otherwise.
    logic [31:0] rf_mem [32] = '{default: '0};
    logic [31:0] rd1 = '0;
    logic        rd1_v = 1'b0;
    logic [31:0] rd2 = '0;
    assign du_rf_q_i = rd2;
    always @(posedge clk_i) begin
        if (du_we_rf_o) rf_mem[du_addr_o[4:0]] <= du_d_o;
        rd1   <= rf_mem[du_addr_o[4:0]];
        rd1_v <= du_re_rf_o;
        rd2   <= rd1_v ? rd1 : $urandom;
    end

    typedef struct {
        logic        we;
        logic [11:0] a;
        logic [31:0] d;
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
        int          strobes;
    } exp_t;

    exp_t exp_q[$];

    // Monitor
    int seen = 0;
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_ni) begin
            seen = 0;
        end else begin
            if (du_re_rf_o || du_we_rf_o) begin
                check("re_we_exclusive", {63'b0, du_re_rf_o & du_we_rf_o}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("spurious_strobe", {62'b0, du_re_rf_o, du_we_rf_o}, 64'd0);
                end else begin
                    e = exp_q[0];
                    check("strobe_kind", {63'b0, du_we_rf_o}, {63'b0, e.we});
                    check("strobe_cycle", 64'(cyc), 64'(e.acc));
                    check("strobe_addr", {52'b0, du_addr_o}, {52'b0, 7'b0, e.a[4:0]});
                    if (du_we_rf_o) check("strobe_wdata", {32'b0, du_d_o}, {32'b0, e.d});
                    seen++;
                end
            end
            if (dbg_ack_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_ack", {63'b0, dbg_ack_o}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_err", {63'b0, dbg_err_o}, {63'b0, e.err});
                    check("ack_rdata", {32'b0, dbg_rdata_o}, {32'b0, e.rdata});
                    check("ack_latency", 64'(cyc - e.acc), 64'(e.lat));
                    check("strobe_count", 64'(seen), 64'(e.strobes));
                end
                seen = 0;
            end
        end
    end

    // Reference model state
    logic [31:0] ref_rf [32] = '{default: '0};
    logic [31:0] last_rd = '0;

    task automatic push_exp(input logic we, input logic [11:0] a, input logic [31:0] d);
        exp_t e;
        e.we = we; e.a = a; e.d = d; e.acc = cyc + 1; e.err = 1'b0;
`ifdef RV_DU_RF_ADDR_CHECK_EN
        e.err = (a[11:5] != 7'd0);
`endif
        if (e.err) begin
            e.lat = 0; e.strobes = 0; e.rdata = last_rd;
        end else if (we) begin
            e.lat = 1;
            e.strobes = (a[4:0] != 5'd0) ? 1 : 0;
            if (a[4:0] != 5'd0) ref_rf[a[4:0]] = d;
            e.rdata = last_rd;
        end else begin
            e.lat = 3; e.strobes = 1;
            e.rdata = (a[4:0] == 5'd0) ? 32'd0 : ref_rf[a[4:0]];
            last_rd = e.rdata;
        end
        exp_q.push_back(e);
    endtask

    task automatic do_op(input logic we, input logic [11:0] a, input logic [31:0] d,
                         input int stall_delay, input logic drop_stall);
        int n;
        @(negedge clk_i);
        dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = d;
        du_stall_i = (stall_delay == 0);
        if (stall_delay > 0) begin
            repeat (stall_delay) @(negedge clk_i);
            du_stall_i = 1'b1;
        end
        push_exp(we, a, d);
        @(negedge clk_i);
        if (drop_stall) du_stall_i = 1'b0;
        for (n = 0; n < 30 && !dbg_ack_o; n++) @(negedge clk_i);
        if (!dbg_ack_o) begin
            check("ack_timeout", 64'd0, 64'd1);
            exp_q.delete();
        end
        dbg_req_i = 1'b0;
        du_stall_i = 1'b1;
    endtask

    initial begin
        logic [11:0] a;
        repeat (3) @(negedge clk_i);
        check("reset_outputs_a", {61'b0, dbg_ack_o, dbg_err_o, du_re_rf_o | du_we_rf_o}, 64'd0);
        check("reset_outputs_b", {20'b0, du_addr_o, dbg_rdata_o}, 64'd0);
        check("reset_wdata", {32'b0, du_d_o}, 64'd0);
        rst_ni = 1'b1;
        du_stall_i = 1'b1;

        do_op(1'b1, 12'h005, 32'hDEADBEEF, 0, 1'b0);
        do_op(1'b0, 12'h005, 32'h0, 0, 1'b0);
        do_op(1'b1, 12'h000, 32'h12345678, 0, 1'b0);
        do_op(1'b0, 12'h000, 32'h0, 0, 1'b0);
        do_op(1'b0, 12'h005, 32'h0, 10, 1'b0);
        do_op(1'b0, 12'h025, 32'h0, 0, 1'b0);
        do_op(1'b1, 12'h7E3, 32'hCAFEF00D, 0, 1'b1);
        do_op(1'b0, 12'h003, 32'h0, 0, 1'b1);

        for (int i = 0; i < 150; i++) begin
            a = 12'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) a[11:5] = 7'($urandom_range(1, 127));
            do_op(1'($urandom_range(0, 1)), a, $urandom,
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0,
                  1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        // Reset while the read waits for RF data: outputs clear at once, no ack afterwards.
        @(negedge clk_i);
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 12'h005;
        push_exp(1'b0, 12'h005, 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        dbg_req_i = 1'b0;
        exp_q.delete();
        last_rd = '0;
        #1;
        check("midop_reset_a", {61'b0, dbg_ack_o, dbg_err_o, du_re_rf_o | du_we_rf_o}, 64'd0);
        check("midop_reset_b", {20'b0, du_addr_o, dbg_rdata_o}, 64'd0);
        check("midop_reset_wdata", {32'b0, du_d_o}, 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (10) @(negedge clk_i);
        check("post_reset_rdata", {32'b0, dbg_rdata_o}, 64'd0);
        do_op(1'b0, 12'h005, 32'h0, 0, 1'b0);

        repeat (3) @(negedge clk_i);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/riscv_du_rf_access.md
RISCV_DU_RF_ACCESS -- requirements
Module: riscv_du_rf_access

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning general-purpose register width.
REQ-002 The block SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port dbg_req_i, input, 1 bit: debugger register-access request, held high until dbg_ack_o.
REQ-005 The block SHALL have port dbg_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-006 The block SHALL have port dbg_addr_i, input, 12 bits: register address; bits [4:0] select x0..x31.
REQ-007 The block SHALL have port dbg_wdata_i, input, XLEN bits: write data.
REQ-008 The block SHALL have port dbg_ack_o, output, 1 bit: single-cycle completion pulse.
REQ-009 The block SHALL have port dbg_rdata_o, output, XLEN bits: read data, valid with dbg_ack_o and held until the next read completes.
REQ-010 The block SHALL have port dbg_err_o, output, 1 bit: error flag, valid with dbg_ack_o.
REQ-011 The block SHALL have port du_stall_i, input, 1 bit: core halted; RF accesses are permitted only while it is high.
REQ-012 The block SHALL have port du_re_rf_o, output, 1 bit: RF debug read strobe.
REQ-013 The block SHALL have port du_we_rf_o, output, 1 bit: RF debug write strobe.
REQ-014 The block SHALL have port du_addr_o, output, 12 bits: RF debug address.
REQ-015 The block SHALL have port du_d_o, output, XLEN bits: RF debug write data.
REQ-016 The block SHALL have port du_rf_q_i, input, XLEN bits: RF debug read data, registered by the RF and valid 2 cycles after the du_re_rf_o cycle.

Function
REQ-017 The state machine SHALL have the states IDLE, RD, RD_W, RD_CAP, WR and ACK; all outputs SHALL be registered.
REQ-018 In IDLE, when dbg_req_i=1 and du_stall_i=1, the block SHALL latch the address, we and wdata, then go to WR when dbg_we_i=1, otherwise to RD.
REQ-019 In IDLE, when dbg_req_i=1 and du_stall_i=0, the block SHALL stay in IDLE with no RF strobes and no ack; the request remains pending.
REQ-020 In RD, the block SHALL assert du_re_rf_o for exactly 1 cycle with du_addr_o = latched address; next state RD_W.
REQ-021 In RD_W, the block SHALL wait 1 cycle; next state RD_CAP.
REQ-022 In RD_CAP, the block SHALL sample du_rf_q_i into dbg_rdata_o; next state ACK.
REQ-023 In WR, the block SHALL assert du_we_rf_o for exactly 1 cycle with du_addr_o and du_d_o = latched values; next state ACK.
REQ-024 In WR, when the latched address bits [4:0] = 0, the block SHALL suppress du_we_rf_o and still complete through ACK.
REQ-025 In ACK, dbg_ack_o SHALL be high for exactly 1 cycle; next state IDLE.
REQ-026 The requester SHALL drop dbg_req_i in the ack cycle; a dbg_req_i still high in the following IDLE cycle SHALL be treated as a new request.
REQ-027 Latency SHALL be: read, ack 4 cycles after the accepting IDLE edge; write, ack 2 cycles after.
REQ-028 du_re_rf_o and du_we_rf_o SHALL never be high in the same cycle.
REQ-029 du_addr_o and du_d_o SHALL hold their last values outside RD and WR.
REQ-030 When du_stall_i falls mid-operation, the block SHALL complete the operation normally.
REQ-031 Without the configuration macro, dbg_err_o SHALL be constant 0.

Reset
REQ-032 When rst_ni=0, the block SHALL asynchronously force state IDLE and all outputs to 0, including dbg_rdata_o, du_addr_o and du_d_o.
REQ-033 A reset asserted mid-operation SHALL abort it, with no ack and no further strobes after release.

Configuration
REQ-034 Macro RV_DU_RF_ADDR_CHECK_EN, when defined, SHALL make a request with dbg_addr_i[11:5] != 0 go directly IDLE -> ACK with dbg_err_o=1, no RF strobe and dbg_rdata_o unchanged.
REQ-035 When RV_DU_RF_ADDR_CHECK_EN is undefined, the block SHALL ignore bits [11:5], use only bits [4:0] and drive du_addr_o[11:5]=0.

Verification
REQ-036 The bench SHALL cover: write addr 5, data 0xDEADBEEF, stall=1 -> one du_we_rf_o pulse with du_addr_o=0x005 and du_d_o=0xDEADBEEF, then dbg_ack_o 1 cycle later, err=0.
REQ-037 The bench SHALL cover: read addr 5 with an RF model returning 0xDEADBEEF -> one du_re_rf_o pulse, then dbg_ack_o 4 cycles after acceptance with dbg_rdata_o=0xDEADBEEF.
REQ-038 The bench SHALL cover: write addr 0, data 0x12345678 -> no du_we_rf_o, dbg_ack_o after 2 cycles.
REQ-039 The bench SHALL cover: read request with du_stall_i=0 for 10 cycles, then 1 -> no strobes for 10 cycles, then the normal read sequence.
REQ-040 The bench SHALL cover: with the macro defined, read addr 0x025 -> dbg_ack_o with dbg_err_o=1 the cycle after acceptance and no du_re_rf_o.
REQ-041 The bench SHALL cover: rst_ni low in RD_W -> all outputs 0 immediately, no dbg_ack_o afterwards.
